// File: rtl/shift_engine_pkg.sv
// Shared definitions for the shift engine: op encodings and the
// burst sequencer state type.
package shift_engine_pkg;

  // Shift operation encodings carried on the op input.
  localparam logic [1:0] OP_LOG = 2'b00;  // logical, serial fill
  localparam logic [1:0] OP_ROT = 2'b01;  // rotate, wraps modulo N
  localparam logic [1:0] OP_ARI = 2'b10;  // arithmetic right / zero-fill left
  localparam logic [1:0] OP_RSV = 2'b11;  // reserved, behaves as logical

  // Burst sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage : shift_engine_pkg

// File: rtl/shift_step_comb.sv
// One shift step of W bits on an N-bit value. Purely combinational;
// the caller decides whether direction/op come live or from a latch.
module shift_step_comb
  import shift_engine_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 1
) (
  input  logic [N-1:0] i_r,
  input  logic         i_right,
  input  logic [1:0]   i_op,
  input  logic [W-1:0] i_sil,
  input  logic [W-1:0] i_sir,
  output logic [N-1:0] o_r_next
);

  // Candidate results for each direction/op pair.
  logic [N-1:0] w_log_right;
  logic [N-1:0] w_log_left;
  logic [N-1:0] w_rot_right;
  logic [N-1:0] w_rot_left;
  logic [N-1:0] w_ari_right;
  logic [N-1:0] w_ari_left;

  assign w_log_right = {i_sir, i_r[N-1:W]};
  assign w_log_left  = {i_r[N-W-1:0], i_sil};
  assign w_rot_right = {i_r[W-1:0], i_r[N-1:W]};
  assign w_rot_left  = {i_r[N-W-1:0], i_r[N-1:N-W]};
  // Arithmetic right replicates the sign bit; serial fill is ignored.
  assign w_ari_right = {{W{i_r[N-1]}}, i_r[N-1:W]};
  // Arithmetic left is a plain zero fill; serial fill is ignored.
  assign w_ari_left  = {i_r[N-W-1:0], {W{1'b0}}};

  // Select the result for the requested direction and op.
  always_comb begin
    o_r_next = i_right ? w_log_right : w_log_left;
    case (i_op)
      OP_ROT:         o_r_next = i_right ? w_rot_right : w_rot_left;
      OP_ARI:         o_r_next = i_right ? w_ari_right : w_ari_left;
      OP_LOG, OP_RSV: o_r_next = i_right ? w_log_right : w_log_left;
      default:        o_r_next = i_right ? w_log_right : w_log_left;
    endcase
  end

endmodule : shift_step_comb

// File: rtl/shift_engine.sv
// Multi-lane shift register with parallel load and a burst sequencer
// that runs a programmed number of W-bit steps from one start strobe.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 1,
  parameter int CW = $clog2(N + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ena,
  input  logic          i_load,
  input  logic [N-1:0]  i_d,
  input  logic          i_start,
  input  logic [CW-1:0] i_steps,
  input  logic          i_right,
  input  logic [1:0]    i_op,
  input  logic [W-1:0]  i_sil,
  input  logic [W-1:0]  i_sir,
  output logic [N-1:0]  o_q,
  output logic [W-1:0]  o_sor,
  output logic [W-1:0]  o_sol,
  output logic          o_busy,
  output logic          o_done
);

  // State registers.
  state_t        r_state;
  logic [N-1:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_right;
  logic [1:0]    r_op;
  logic          r_done;

  // Next-state values.
  state_t        w_state_next;
  logic [N-1:0]  w_q_next;
  logic [CW-1:0] w_cnt_next;
  logic          w_right_next;
  logic [1:0]    w_op_next;
  logic          w_done_next;

  // Step configuration: the first step of a burst uses the live inputs,
  // later steps use the values captured on the start edge.
  logic          w_cfg_right;
  logic [1:0]    w_cfg_op;
  logic [N-1:0]  w_step_q;

  assign w_cfg_right = (r_state == RUN) ? r_right : i_right;
  assign w_cfg_op    = (r_state == RUN) ? r_op    : i_op;

  shift_step_comb #(
    .N (N),
    .W (W)
  ) u_step (
    .i_r      (r_q),
    .i_right  (w_cfg_right),
    .i_op     (w_cfg_op),
    .i_sil    (i_sil),
    .i_sir    (i_sir),
    .o_r_next (w_step_q)
  );

  // Sequencer next-state, data path selection and done generation.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = r_q;
    w_cnt_next   = r_cnt;
    w_right_next = r_right;
    w_op_next    = r_op;
    w_done_next  = 1'b0;  // done is a single-cycle pulse, even with ena low
    if (i_ena) begin
      case (r_state)
        IDLE: begin
          if (i_load) begin
            w_q_next = i_d;
          end else if (i_start) begin
            if (i_steps == '0) begin
              w_done_next = 1'b1;
            end else if (i_steps == CW'(1)) begin
              w_q_next    = w_step_q;
              w_done_next = 1'b1;
            end else begin
              w_q_next     = w_step_q;
              w_cnt_next   = i_steps - CW'(1);
              w_right_next = i_right;
              w_op_next    = i_op;
              w_state_next = RUN;
            end
          end
        end
        RUN: begin
          if (i_load) begin
            // Load aborts the burst without reporting completion.
            w_q_next     = i_d;
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end else begin
            w_q_next   = w_step_q;
            w_cnt_next = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              w_state_next = IDLE;
              w_done_next  = 1'b1;
            end
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  // Register update; reset aborts any burst immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_right <= 1'b0;
      r_op    <= OP_LOG;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_cnt   <= w_cnt_next;
      r_right <= w_right_next;
      r_op    <= w_op_next;
      r_done  <= w_done_next;
    end
  end

  assign o_q    = r_q;
  assign o_sor  = r_q[W-1:0];
  assign o_sol  = r_q[N-1:N-W];
  assign o_busy = (r_state == RUN);
  assign o_done = r_done;

endmodule : shift_engine

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: directed scenarios plus randomized
// bursts compared against an arithmetic reference model.
module tb_shift_engine;

  localparam int N  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // DUT A: N=8, W=1
  logic          a_ena, a_load, a_start, a_right;
  logic [N-1:0]  a_d;
  logic [CW-1:0] a_steps;
  logic [1:0]    a_op;
  logic [0:0]    a_sil, a_sir, a_sor, a_sol;
  logic [N-1:0]  a_q;
  logic          a_busy, a_done;

  // DUT B: N=8, W=2
  logic          b_ena, b_load, b_start, b_right;
  logic [N-1:0]  b_d;
  logic [CW-1:0] b_steps;
  logic [1:0]    b_op;
  logic [1:0]    b_sil, b_sir, b_sor, b_sol;
  logic [N-1:0]  b_q;
  logic          b_busy, b_done;

  int checks   = 0;
  int failures = 0;

  shift_engine #(.N(N), .W(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_ena(a_ena), .i_load(a_load), .i_d(a_d),
    .i_start(a_start), .i_steps(a_steps), .i_right(a_right), .i_op(a_op),
    .i_sil(a_sil), .i_sir(a_sir), .o_q(a_q), .o_sor(a_sor), .o_sol(a_sol),
    .o_busy(a_busy), .o_done(a_done)
  );

  shift_engine #(.N(N), .W(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_ena(b_ena), .i_load(b_load), .i_d(b_d),
    .i_start(b_start), .i_steps(b_steps), .i_right(b_right), .i_op(b_op),
    .i_sil(b_sil), .i_sir(b_sir), .o_q(b_q), .o_sor(b_sor), .o_sol(b_sol),
    .o_busy(b_busy), .o_done(b_done)
  );

  // Reference: one step of w bits on an 8-bit value, by plain integer math.
  function automatic logic [7:0] ref_step(input logic [7:0] r, input int w,
                                          input logic rt, input logic [1:0] o,
                                          input logic [7:0] sl, input logic [7:0] sr);
    int ri, m, res, sv;
    ri = int'(r);
    m  = (1 << w) - 1;
    case (o)
      2'b01: res = rt ? ((ri >> w) | (ri << (8 - w))) : ((ri << w) | (ri >> (8 - w)));
      2'b10: begin
        sv  = r[7] ? (ri - 256) : ri;
        res = rt ? (sv >>> w) : (ri << w);
      end
      default: res = rt ? ((ri >> w) | ((int'(sr) & m) << (8 - w)))
                        : ((ri << w) | (int'(sl) & m));
    endcase
    return 8'(res & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load_val(input logic [7:0] v);
    a_load = 1'b1;
    a_d    = v;
    tick();
    a_load = 1'b0;
  endtask

  // Wait (bounded) for done on DUT A; n = edges waited, -1 on timeout.
  task automatic a_wait_done(input int max_edges, output int n);
    n = -1;
    for (int i = 0; i < max_edges; i++) begin
      if (a_done) begin
        n = i;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (a_q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", a_q); end
    checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b done=%b exp=0/0", a_busy, a_done); end
    checks++; if (a_sor !== 1'b0 || a_sol !== 1'b0) begin failures++; $display("FAIL reset_so sor=%b sol=%b exp=0/0", a_sor, a_sol); end
    checks++; if (b_q !== 8'h00 || b_busy !== 1'b0) begin failures++; $display("FAIL reset_b q=%h busy=%b exp=00/0", b_q, b_busy); end
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("test_reset: q=%h busy=%b done=%b", a_q, a_busy, a_done);
  endtask

  task automatic test_single_step();
    a_load_val(8'hA5);
    checks++; if (a_q !== 8'hA5) begin failures++; $display("FAIL load_q got=%h exp=a5", a_q); end
    a_steps = 4'd1; a_right = 1'b1; a_op = 2'b00; a_sir = 1'b1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++; if (a_q !== 8'hD2) begin failures++; $display("FAIL single_q got=%h exp=d2", a_q); end
    checks++; if (a_done !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL single_flags done=%b busy=%b exp=1/0", a_done, a_busy); end
    checks++; if (a_sor !== 1'b0 || a_sol !== 1'b1) begin failures++; $display("FAIL single_so sor=%b sol=%b exp=0/1", a_sor, a_sol); end
    tick();
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL single_done_clear got=%b exp=0", a_done); end
    $display("test_single_step: q=%h", a_q);
  endtask

  task automatic test_rotate3();
    int busy_cnt, done_at;
    logic [7:0] qd;
    busy_cnt = 0; done_at = -1; qd = 8'h00;
    a_load_val(8'h81);
    a_steps = 4'd3; a_right = 1'b0; a_op = 2'b01; a_start = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      a_start = 1'b0;
      if (a_busy) busy_cnt++;
      if (a_done && done_at < 0) begin done_at = e; qd = a_q; end
    end
    checks++; if (qd !== 8'h0C) begin failures++; $display("FAIL rot3_q got=%h exp=0c", qd); end
    checks++; if (busy_cnt != 2) begin failures++; $display("FAIL rot3_busy got=%0d exp=2", busy_cnt); end
    checks++; if (done_at != 3) begin failures++; $display("FAIL rot3_done_edge got=%0d exp=3", done_at); end
    $display("test_rotate3: q=%h busy_cycles=%0d done_edge=%0d", qd, busy_cnt, done_at);
  endtask

  task automatic test_arith();
    logic [7:0] vin [2];
    logic [7:0] vexp [2];
    int n;
    vin[0] = 8'h80; vexp[0] = 8'hFF;
    vin[1] = 8'h40; vexp[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      a_load_val(vin[i]);
      a_steps = 4'd7; a_right = 1'b1; a_op = 2'b10; a_sir = 1'b1; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      a_wait_done(20, n);
      checks++; if (n < 0) begin failures++; $display("FAIL arith_timeout in=%h got=no_done exp=done", vin[i]); end
      checks++; if (a_q !== vexp[i]) begin failures++; $display("FAIL arith_q in=%h got=%h exp=%h", vin[i], a_q, vexp[i]); end
      $display("test_arith: in=%h q=%h", vin[i], a_q);
      tick();
    end
  endtask

  task automatic test_abort();
    int saw_done;
    saw_done = 0;
    a_load_val(8'h3C);
    a_steps = 4'd5; a_right = 1'b0; a_op = 2'b00; a_sil = 1'b1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++; if (a_q !== 8'h79) begin failures++; $display("FAIL abort_step1 got=%h exp=79", a_q); end
    a_ena = 1'b0;
    tick(); if (a_done) saw_done++;
    tick(); if (a_done) saw_done++;
    checks++; if (a_q !== 8'h79 || a_busy !== 1'b1) begin failures++; $display("FAIL abort_hold q=%h busy=%b exp=79/1", a_q, a_busy); end
    a_ena = 1'b1;
    tick(); if (a_done) saw_done++;
    checks++; if (a_q !== 8'hF3) begin failures++; $display("FAIL abort_step2 got=%h exp=f3", a_q); end
    a_load = 1'b1; a_d = 8'h5A;
    tick(); if (a_done) saw_done++;
    a_load = 1'b0;
    checks++; if (a_q !== 8'h5A || a_busy !== 1'b0) begin failures++; $display("FAIL abort_load q=%h busy=%b exp=5a/0", a_q, a_busy); end
    for (int i = 0; i < 6; i++) begin tick(); if (a_done) saw_done++; end
    checks++; if (saw_done != 0 || a_q !== 8'h5A) begin failures++; $display("FAIL abort_no_done dones=%0d q=%h exp=0/5a", saw_done, a_q); end
    $display("test_abort: q=%h dones=%0d", a_q, saw_done);
  endtask

  task automatic test_zero_steps();
    a_load_val(8'h96);
    a_steps = 4'd0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++; if (a_q !== 8'h96 || a_done !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL zero_steps q=%h done=%b busy=%b exp=96/1/0", a_q, a_done, a_busy); end
    a_ena = 1'b0;
    tick();
    checks++; if (a_done !== 1'b0) begin failures++; $display("FAIL zero_done_clear_ena0 got=%b exp=0", a_done); end
    a_ena = 1'b1;
    $display("test_zero_steps: q=%h", a_q);
  endtask

  task automatic test_back_to_back();
    int n;
    a_load_val(8'h01);
    a_steps = 4'd2; a_right = 1'b0; a_op = 2'b00; a_sil = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_wait_done(10, n);
    checks++; if (n < 0 || a_q !== 8'h04) begin failures++; $display("FAIL b2b_first q=%h wait=%0d exp=04", a_q, n); end
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    checks++; if (a_q !== 8'h08 || a_busy !== 1'b1 || a_done !== 1'b0) begin failures++; $display("FAIL b2b_restart q=%h busy=%b done=%b exp=08/1/0", a_q, a_busy, a_done); end
    a_wait_done(10, n);
    checks++; if (n < 0 || a_q !== 8'h10) begin failures++; $display("FAIL b2b_second q=%h wait=%0d exp=10", a_q, n); end
    tick();
    $display("test_back_to_back: q=%h", a_q);
  endtask

  task automatic test_async_reset();
    a_load_val(8'hFF);
    a_steps = 4'd10; a_right = 1'b1; a_op = 2'b00; a_sir = 1'b0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL areset_pre busy=%b exp=1", a_busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (a_q !== 8'h00 || a_busy !== 1'b0) begin failures++; $display("FAIL areset_now q=%h busy=%b exp=00/0", a_q, a_busy); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("test_async_reset: q=%h busy=%b", a_q, a_busy);
  endtask

  task automatic test_w2();
    b_steps = 4'd4; b_right = 1'b0; b_op = 2'b00; b_sil = 2'b10; b_start = 1'b1;
    tick();
    b_start = 1'b0; b_sil = 2'b01;
    tick();
    b_sil = 2'b11;
    tick();
    b_sil = 2'b00;
    tick();
    checks++; if (b_q !== 8'h9C) begin failures++; $display("FAIL w2_q got=%h exp=9c", b_q); end
    checks++; if (b_sol !== 2'b10 || b_sor !== 2'b00) begin failures++; $display("FAIL w2_so sol=%b sor=%b exp=10/00", b_sol, b_sor); end
    checks++; if (b_done !== 1'b1) begin failures++; $display("FAIL w2_done got=%b exp=1", b_done); end
    tick();
    $display("test_w2: q=%h sol=%b", b_q, b_sol);
  endtask

  task automatic test_random();
    logic [7:0] model, dv, sl, sr;
    logic rt;
    logic [1:0] o;
    int s, last;
    for (int b = 0; b < 30; b++) begin
      dv = 8'($urandom);
      a_load_val(dv);
      model = dv;
      s  = $urandom_range(0, 15);
      rt = 1'($urandom_range(0, 1));
      o  = 2'($urandom_range(0, 3));
      a_steps = 4'(s); a_right = rt; a_op = o; a_start = 1'b1;
      last = (s == 0) ? 0 : s - 1;
      for (int e = 0; e <= last + 1; e++) begin
        sl = 8'($urandom); sr = 8'($urandom);
        a_sil = sl[0]; a_sir = sr[0];
        if (e < s) model = ref_step(model, 1, rt, o, {7'd0, sl[0]}, {7'd0, sr[0]});
        tick();
        // Config and start are don't-cares while running; scramble them.
        a_right = 1'($urandom_range(0, 1));
        a_op    = 2'($urandom_range(0, 3));
        a_start = (e + 1 <= s - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        checks++;
        if (a_busy !== (e < s - 1) || a_done !== (e == last)) begin
          failures++;
          $display("FAIL rand_flags burst=%0d edge=%0d busy=%b done=%b exp=%b/%b", b, e, a_busy, a_done, (e < s - 1), (e == last));
        end
        if (e >= last) begin
          checks++;
          if (a_q !== model) begin
            failures++;
            $display("FAIL rand_q burst=%0d edge=%0d got=%h exp=%h", b, e, a_q, model);
          end
        end
      end
      a_start = 1'b0;
      $display("test_random: burst=%0d d=%h steps=%0d right=%b op=%0d q=%h", b, dv, s, rt, o, a_q);
    end
  endtask

  initial begin
    rst = 1'b0;
    a_ena = 1'b1; a_load = 1'b0; a_start = 1'b0; a_right = 1'b0;
    a_d = '0; a_steps = '0; a_op = 2'b00; a_sil = '0; a_sir = '0;
    b_ena = 1'b1; b_load = 1'b0; b_start = 1'b0; b_right = 1'b0;
    b_d = '0; b_steps = '0; b_op = 2'b00; b_sil = '0; b_sir = '0;
    #2;
    test_reset();
    test_single_step();
    test_rotate3();
    test_arith();
    test_abort();
    test_zero_steps();
    test_back_to_back();
    test_async_reset();
    test_w2();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_engine
